// File: rtl/cordic_sincos_iter_if.sv
// Angle-in / sin-cos-out handshake bundle for cordic_sincos_iter.
// The master side drives angles and accepts results; the slave side is the engine.
interface cordic_sincos_iter_if #(
  parameter int WIDTH = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        angle_in;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] cos_out;
  logic signed [WIDTH-1:0] sin_out;
  logic                    busy;

  modport master (
    output in_valid, angle_in, out_ready,
    input  in_ready, out_valid, cos_out, sin_out, busy
  );

  modport slave (
    input  in_valid, angle_in, out_ready,
    output in_ready, out_valid, cos_out, sin_out, busy
  );
endinterface

// File: rtl/cordic_sincos_iter.sv
// Iterative rotation-mode CORDIC: one binary angle in, cosine/sine out, one micro-rotation per cycle.
// Optional macro CORDIC_CLAMP_EN saturates both outputs to +/-1.0 before they are registered.
module cordic_sincos_iter #(
  parameter int WIDTH = 16,
  parameter int ITER  = 16,
  parameter int GUARD = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  cordic_sincos_iter_if.slave  bus
);

  localparam int XW = WIDTH + GUARD + 1;
  localparam int CW = $clog2(ITER);
  localparam int F  = WIDTH - 2 + GUARD;

  // 0.6072529350 in 0.32 fixed point, rounded into the x/y scale.
  localparam logic [63:0] K_FIX = 64'd2608131496;
  localparam logic [63:0] X0_64 = (K_FIX + (64'd1 << (31 - F))) >> (32 - F);
  localparam logic signed [XW-1:0] X0   = X0_64[XW-1:0];
  localparam logic signed [XW-1:0] RND  = XW'((1 << GUARD) >> 1);
  localparam logic signed [XW-1:0] ONE  = XW'(2 ** (WIDTH - 2));
  localparam logic [WIDTH-1:0]     HALF = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [31:0] atan_bam(input int i);
    case (i)
      0:  atan_bam = 32'h20000000;
      1:  atan_bam = 32'h12E4051E;
      2:  atan_bam = 32'h09FB385B;
      3:  atan_bam = 32'h051111D4;
      4:  atan_bam = 32'h028B0D43;
      5:  atan_bam = 32'h0145D7E1;
      6:  atan_bam = 32'h00A2F61E;
      7:  atan_bam = 32'h00517C55;
      8:  atan_bam = 32'h0028BE53;
      9:  atan_bam = 32'h00145F2F;
      10: atan_bam = 32'h000A2F98;
      11: atan_bam = 32'h000517CC;
      12: atan_bam = 32'h00028BE6;
      13: atan_bam = 32'h000145F3;
      14: atan_bam = 32'h0000A2FA;
      15: atan_bam = 32'h0000517D;
      16: atan_bam = 32'h000028BE;
      17: atan_bam = 32'h0000145F;
      18: atan_bam = 32'h00000A30;
      19: atan_bam = 32'h00000518;
      20: atan_bam = 32'h0000028C;
      21: atan_bam = 32'h00000146;
      22: atan_bam = 32'h000000A3;
      23: atan_bam = 32'h00000051;
      default: atan_bam = 32'h00000000;
    endcase
  endfunction

  // Drop the guard bits with round-half-up, undo the quadrant fold, optionally saturate.
  function automatic logic [WIDTH-1:0] finish_out(input logic signed [XW-1:0] v, input logic neg);
    logic signed [XW-1:0] r;
    r = (v + RND) >>> GUARD;
    if (neg) r = -r;
`ifdef CORDIC_CLAMP_EN
    if (r > ONE) r = ONE;
    else if (r < -ONE) r = -ONE;
`endif
    return WIDTH'(r);
  endfunction

  logic [WIDTH-1:0] atan_tab [ITER];

  for (genvar gi = 0; gi < ITER; gi++) begin : g_atan
    localparam logic [31:0] RAW = atan_bam(gi) + (32'd1 << (31 - WIDTH));
    assign atan_tab[gi] = RAW[31 -: WIDTH];
  end

  typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [XW-1:0]    x_q, x_d, y_q, y_d;
  logic [WIDTH-1:0]        z_q, z_d;
  logic                    neg_q, neg_d;
  logic [WIDTH-1:0]        cos_q, cos_d, sin_q, sin_d;

  logic                    last;
  logic [1:0]              quad;
  logic                    fold;
  logic signed [XW-1:0]    x_sh, y_sh, x_next, y_next;
  logic [WIDTH-1:0]        z_next, atan_cur;

  assign last     = (cnt_q == CW'(ITER - 1));
  assign quad     = bus.angle_in[WIDTH-1:WIDTH-2];
  assign fold     = (quad == 2'b01) || (quad == 2'b10);
  assign atan_cur = atan_tab[cnt_q];
  assign x_sh     = x_q >>> cnt_q;
  assign y_sh     = y_q >>> cnt_q;

  always_comb begin
    x_next = x_q;
    y_next = y_q;
    z_next = z_q;
    if (!z_q[WIDTH-1]) begin
      x_next = x_q - y_sh;
      y_next = y_q + x_sh;
      z_next = z_q - atan_cur;
    end else begin
      x_next = x_q + y_sh;
      y_next = y_q - x_sh;
      z_next = z_q + atan_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.in_valid) state_d = S_ROTATE;
      S_ROTATE: if (last)         state_d = S_DONE;
      S_DONE:   if (bus.out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    x_d   = x_q;
    y_d   = y_q;
    z_d   = z_q;
    neg_d = neg_q;
    cos_d = cos_q;
    sin_d = sin_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          cnt_d = '0;
          x_d   = X0;
          y_d   = '0;
          z_d   = fold ? (bus.angle_in - HALF) : bus.angle_in;
          neg_d = fold;
        end
      end
      S_ROTATE: begin
        x_d   = x_next;
        y_d   = y_next;
        z_d   = z_next;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          cnt_d = '0;
          cos_d = finish_out(x_next, neg_q);
          sin_d = finish_out(y_next, neg_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      neg_q <= 1'b0;
      cos_q <= '0;
      sin_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      x_q   <= x_d;
      y_q   <= y_d;
      z_q   <= z_d;
      neg_q <= neg_d;
      cos_q <= cos_d;
      sin_q <= sin_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_ROTATE);
  assign bus.cos_out   = cos_q;
  assign bus.sin_out   = sin_q;

endmodule

// File: tb/tb_cordic_sincos_iter.sv
// Randomised self-checking bench for cordic_sincos_iter against a real-math reference.
// Define CORDIC_CLAMP_EN for both bench and RTL to exercise the saturating build.
module tb_cordic_sincos_iter;
  localparam int    W  = 16;
  localparam int    IT = 16;
  localparam int    G  = 2;
  localparam real   PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cordic_sincos_iter_if #(.WIDTH(W)) bus();

  cordic_sincos_iter #(.WIDTH(W), .ITER(IT), .GUARD(G)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int atan_m [IT];
  int x0_m;

  task automatic check(input string tag, input int got, input int exp, input int tol);
    int diff;
    diff = got - exp;
    n_cmp++;
    if (diff > tol || diff < -tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Reference constants straight from the math: atan(2^-i) as a binary angle, and the CORDIC gain.
  task automatic build_tables();
    real p;
    real v;
    int  cst;
    p = 1.0;
    for (int i = 0; i < IT; i++) begin
      v   = $atan(p) / (2.0 * PI) * 4294967296.0;
      cst = $rtoi($floor(v + 0.5));
      atan_m[i] = (cst + (1 << (31 - W))) >>> (32 - W);
      p = p / 2.0;
    end
    x0_m = $rtoi($floor(0.6072529350 * (2.0 ** (W - 2 + G)) + 0.5));
  endtask

  task automatic ref_model(input int a, output int c, output int s);
    int     half;
    int     full;
    int     q;
    int     z;
    bit     neg;
    longint x;
    longint y;
    longint xn;
    half = 1 << (W - 1);
    full = 1 << W;
    q    = (a >> (W - 2)) & 3;
    if (q == 1 || q == 2) begin
      z   = (a - half) & (full - 1);
      neg = 1'b1;
    end else begin
      z   = a;
      neg = 1'b0;
    end
    if (z >= half) z -= full;
    x = x0_m;
    y = 0;
    for (int i = 0; i < IT; i++) begin
      if (z >= 0) begin
        xn = x - (y >>> i);
        y  = y + (x >>> i);
        z  = z - atan_m[i];
      end else begin
        xn = x + (y >>> i);
        y  = y - (x >>> i);
        z  = z + atan_m[i];
      end
      x = xn;
      if (z >= half) z -= full;
      else if (z < -half) z += full;
    end
    c = int'((x + (1 << (G - 1))) >>> G);
    s = int'((y + (1 << (G - 1))) >>> G);
    if (neg) begin
      c = -c;
      s = -s;
    end
`ifdef CORDIC_CLAMP_EN
    if (c >  (1 << (W - 2))) c =  (1 << (W - 2));
    if (c < -(1 << (W - 2))) c = -(1 << (W - 2));
    if (s >  (1 << (W - 2))) s =  (1 << (W - 2));
    if (s < -(1 << (W - 2))) s = -(1 << (W - 2));
`endif
  endtask

  task automatic ideal(input int a, output int c, output int s);
    real th;
    th = 2.0 * PI * a / (2.0 ** W);
    c  = $rtoi($floor((2.0 ** (W - 2)) * $cos(th) + 0.5));
    s  = $rtoi($floor((2.0 ** (W - 2)) * $sin(th) + 0.5));
  endtask

  // Presents one angle, waits for the result (bounded), then consumes it after `stall` cycles.
  task automatic do_txn(input int a, input int stall, output int c, output int s);
    int wait_cnt;
    int lat;
    wait_cnt = 0;
    while (!bus.in_ready && wait_cnt < 50) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check("in_ready_before_accept", int'(bus.in_ready), 1, 0);
    bus.angle_in = W'(a);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.angle_in = W'($urandom);
    check("busy_after_accept", int'(bus.busy), 1, 0);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, IT, 0);
    c = int'(bus.cos_out);
    s = int'(bus.sin_out);
    repeat (stall) begin
      @(posedge clk); #1;
    end
    check("cos_held", int'(bus.cos_out), c, 0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("idle_after_release", int'(bus.in_ready), 1, 0);
    check("valid_drop_after_release", int'(bus.out_valid), 0, 0);
    $display("txn angle=0x%04h cos=%0d sin=%0d lat=%0d", a[W-1:0], c, s, lat);
  endtask

  initial begin
    int angs [6];
    int c, s, ec, es, ic, is;
    int a;
    int ov_seen;
    int hold_c, hold_s;
    int lat;
    int lim;

    angs = '{32'h0000, 32'h4000, 32'h8000, 32'hC000, 32'h2000, 32'hE000};
    build_tables();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.angle_in  = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  int'(bus.in_ready),  1, 0);
    check("rst_out_valid", int'(bus.out_valid), 0, 0);
    check("rst_cos",       int'(bus.cos_out),   0, 0);
    check("rst_sin",       int'(bus.sin_out),   0, 0);
    check("rst_busy",      int'(bus.busy),      0, 0);
    rst = 1'b0;

    for (int k = 0; k < 6; k++) begin
      do_txn(angs[k], 0, c, s);
      ideal(angs[k], ic, is);
      ref_model(angs[k], ec, es);
      check("cos_ideal", c, ic, 4);
      check("sin_ideal", s, is, 4);
      check("cos_model", c, ec, 0);
      check("sin_model", s, es, 0);
    end

    // Back-pressure: result must hold and in_valid pulses must be ignored.
    a = 32'h1234;
    bus.angle_in = W'(a);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_latency", lat, IT, 0);
    hold_c = int'(bus.cos_out);
    hold_s = int'(bus.sin_out);
    ref_model(a, ec, es);
    check("bp_cos_model", hold_c, ec, 0);
    check("bp_sin_model", hold_s, es, 0);
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = k[0];
      bus.angle_in = W'($urandom);
      @(posedge clk); #1;
      check("bp_out_valid", int'(bus.out_valid), 1, 0);
      check("bp_in_ready",  int'(bus.in_ready),  0, 0);
      check("bp_cos_stable", int'(bus.cos_out), hold_c, 0);
      check("bp_sin_stable", int'(bus.sin_out), hold_s, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_release_idle", int'(bus.in_ready), 1, 0);
    check("bp_release_busy", int'(bus.busy), 0, 0);
    $display("txn angle=0x%04h cos=%0d sin=%0d backpressure", a[W-1:0], hold_c, hold_s);

    // Reset during iteration 5 must abandon the angle.
    bus.angle_in = W'(32'h2000);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready",  int'(bus.in_ready),  1, 0);
    check("abort_busy",      int'(bus.busy),      0, 0);
    check("abort_out_valid", int'(bus.out_valid), 0, 0);
    check("abort_cos",       int'(bus.cos_out),   0, 0);
    ov_seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.out_valid) ov_seen++;
    end
    check("abort_no_valid", ov_seen, 0, 0);
    $display("txn angle=0x2000 aborted by reset");
    do_txn(32'h4000, 1, c, s);
    ideal(32'h4000, ic, is);
    check("post_abort_cos", c, ic, 4);
    check("post_abort_sin", s, is, 4);

`ifdef CORDIC_CLAMP_EN
    lim = 1 << (W - 2);
`else
    lim = (1 << (W - 2)) + 4;
`endif
    for (int k = 0; k < 150; k++) begin
      a = int'($urandom_range(0, (1 << W) - 1));
      do_txn(a, int'($urandom_range(0, 3)), c, s);
      ref_model(a, ec, es);
      check("rand_cos_model", c, ec, 0);
      check("rand_sin_model", s, es, 0);
      check("rand_cos_range", c, 0, lim);
      check("rand_sin_range", s, 0, lim);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cordic_sincos_iter.md
Name: cordic_sincos_iter

Overview:
- Parametrised iterative CORDIC engine in rotation mode: accepts one angle and returns its cosine and sine.
- Next generation of the existing fixed 16-bit sine/cosine path. Width and iteration count are parameters.
- Adds full-circle quadrant folding, valid/ready handshakes on both sides and a single explicit FSM.
- Sits between the angle generator (NCO/phase accumulator) and downstream mixers; one result per transaction.

Parameters:
- WIDTH, 16, angle and output width in bits; legal range 8..24.
- ITER, 16, micro-rotations per transaction; legal range 4..WIDTH.
- GUARD, 2, extra LSBs carried in the internal x/y datapath.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  angle_in is valid.
- in_ready  out  1  block can accept an angle.
- angle_in  in  WIDTH  binary angle, unsigned; 2^WIDTH = 360 deg, 0x4000 = 90 deg at WIDTH=16.
- out_valid  out  1  cos_out/sin_out are valid.
- out_ready  in  1  consumer accepts the result.
- cos_out  out  WIDTH  signed, 1.0 = 2^(WIDTH-2).
- sin_out  out  WIDTH  signed, same format as cos_out.
- busy  out  1  high in ROTATE.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, cos_out=0, sin_out=0, busy=0, iteration counter=0. Applies from any state, including mid-rotation; any in-flight result is discarded.
- FSM:
  - IDLE --(in_valid&in_ready)--> ROTATE.
  - ROTATE --(counter==ITER-1)--> DONE.
  - DONE --(out_ready)--> IDLE.
- in_ready=1 only in IDLE. out_valid=1 only in DONE.
- Accept cycle, quadrant fold:
  - q = angle_in[WIDTH-1:WIDTH-2].
  - If q is 1 or 2: z0 = angle_in - 2^(WIDTH-1) (mod 2^WIDTH, signed) and the negate flag is set.
  - Otherwise z0 = angle_in as signed and the flag is clear.
  - Residual z0 lies in [-90,+90) deg.
- Initial vector: x0 = round(0.6072529350 * 2^(WIDTH-2+GUARD)), y0 = 0. Gain is precompensated, so no output multiply.
- ROTATE iteration i (i = 0..ITER-1), one per cycle:
  - d = ~z[WIDTH-1].
  - d=1: x' = x - (y>>>i), y' = y + (x>>>i), z' = z - atan_i.
  - d=0: the opposite signs on all three.
  - Shifts are arithmetic.
  - x/y width = WIDTH+GUARD+1 signed; z width = WIDTH signed, wraps mod 2^WIDTH.
- atan table:
  - 32-bit BAM constants, rounded; the first three are 0x20000000, 0x12E4051E, 0x09FB385B.
  - Entry i is used as round(const_i / 2^(32-WIDTH)).
  - Entries that round to 0 are still iterated; shifts still apply.
- Entering DONE:
  - Outputs = round-half-up of x,y dropping GUARD LSBs, negated if the flag is set.
  - Registered outputs hold stable while out_valid=1 and out_ready=0.
- Latency: accept at cycle T gives out_valid at T+ITER+1.
- Throughput: one result per ITER+2 cycles with out_ready tied high. A new angle may be accepted on the cycle after the DONE->IDLE handshake.
- in_valid is ignored outside IDLE; no queuing.
- Accuracy at WIDTH=16, ITER=16: |error| <= 4 LSB on each output.

Optional Feature:
- Macro: CORDIC_CLAMP_EN.
- Defined: each output is saturated to [-2^(WIDTH-2), +2^(WIDTH-2)] before registering, so |cos|,|sin| never exceed 1.0 code. The comparator adds no latency.
- Undefined: raw rounded values are registered. At most a few LSB of overshoot past 1.0 are possible.

Test Plan:
- Reset check, WIDTH=16: hold rst for 2 cycles -> in_ready=1, out_valid=0, cos_out=sin_out=0, busy=0.
- Cardinal angles 0x0000 / 0x4000 / 0x8000 / 0xC000 -> (cos,sin) within 4 LSB of (16384,0) / (0,16384) / (-16384,0) / (0,-16384); out_valid exactly 17 cycles after accept.
- 45-deg angle 0x2000 -> cos,sin both 11585 +-4. Angle 0xE000 -> cos 11585, sin -11585, +-4.
- Back-pressure: out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout. in_valid pulses in that window are not accepted. Release -> IDLE next cycle.
- Reset mid-operation: assert rst at iteration 5 -> next cycle state IDLE, out_valid never asserted for that angle. A fresh 0x4000 afterwards gives the correct result.
- Clamp, with CORDIC_CLAMP_EN: sweep all 65536 angles -> every output in [-16384,16384]. Without the macro, the same sweep stays within 4 LSB of the ideal value.
